// File: rtl/minimicro_pkg.sv
// Shared MiniMicro core constants and the architectural word type.
// Register index width and the PC index are fixed by the ISA, not by a build option.
package minimicro_pkg;
   localparam int DATA_W    = 32;
   localparam int REG_IDX_W = 4;
   localparam int PC_IDX    = 15;

   typedef logic [DATA_W-1:0] word_t;
endpackage

// File: rtl/regfile_read_port.sv
// One combinational read port: range check, PC redirect, and register select.
// Zero latency. There is no flow control, and the output always follows the inputs.
module regfile_read_port #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 9,
   parameter int NREGS  = 16,
   parameter int PC_IDX = 15
) (
   input  logic [ADDR_W-1:0]             addr_i,
   input  logic [DATA_W-1:0]             r15_i,
   input  logic [NREGS-1:0][DATA_W-1:0]  regs_i,
   output logic [DATA_W-1:0]             rd_o
);
   import minimicro_pkg::*;

   localparam logic [REG_IDX_W-1:0] PC_SEL = REG_IDX_W'(PC_IDX);

   logic                 addr_vld;
   logic [REG_IDX_W-1:0] idx;

   assign addr_vld = ((addr_i >> REG_IDX_W) == '0);
   assign idx      = addr_i[REG_IDX_W-1:0];

   always_comb begin
      rd_o = '0;
      if (addr_vld) begin
         if (idx == PC_SEL) rd_o = r15_i;
         else               rd_o = regs_i[idx];
      end
   end
endmodule

// File: rtl/register_file.sv
// MiniMicro architectural register file: 15 stored words, index 15 reads the external PC+8.
// Two combinational reads and one write per clock. There is no flow control.
module register_file #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 9,
   parameter int NREGS  = 16,
   parameter int PC_IDX = 15
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] A1,
   input  logic [ADDR_W-1:0] A2,
   input  logic [ADDR_W-1:0] A3,
   input  logic [DATA_W-1:0] WD3,
   input  logic              WE3,
   input  logic [DATA_W-1:0] R15,
   output logic [DATA_W-1:0] RD1,
   output logic [DATA_W-1:0] RD2
);
   import minimicro_pkg::*;

   logic                            a3_vld;
   logic [REG_IDX_W-1:0]            a3_idx;
   logic [NREGS-1:0]                wr_en;
   logic [NREGS-1:0][DATA_W-1:0]    regs_view;

   assign a3_vld = ((A3 >> REG_IDX_W) == '0);
   assign a3_idx = A3[REG_IDX_W-1:0];

   for (genvar i = 0; i < NREGS; i++) begin : g_reg
      if (i != PC_IDX) begin : g_store
         logic [DATA_W-1:0] data_q;
         logic [DATA_W-1:0] data_d;

         assign wr_en[i] = WE3 && a3_vld && (a3_idx == REG_IDX_W'(i));
         assign data_d   = wr_en[i] ? WD3 : data_q;

         always_ff @(posedge clk or negedge rst) begin
            if (!rst) data_q <= '0;
            else      data_q <= data_d;
         end

         assign regs_view[i] = data_q;
      end else begin : g_pc
         // The PC slot has no storage. The read port redirects this index before the mux.
         assign wr_en[i]     = 1'b0;
         assign regs_view[i] = '0;
      end
   end

   regfile_read_port #(
      .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NREGS(NREGS), .PC_IDX(PC_IDX)
   ) u_rd1 (
      .addr_i(A1), .r15_i(R15), .regs_i(regs_view), .rd_o(RD1)
   );

   regfile_read_port #(
      .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NREGS(NREGS), .PC_IDX(PC_IDX)
   ) u_rd2 (
      .addr_i(A2), .r15_i(R15), .regs_i(regs_view), .rd_o(RD2)
   );
endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: expected words are queued when stimulus is driven.
module tb_register_file;
   logic        clk = 1'b0;
   logic        rst;
   logic [8:0]  A1, A2, A3;
   logic [31:0] WD3, R15, RD1, RD2;
   logic        WE3;

   logic [31:0] exp_q[$];
   logic [31:0] exp1, exp2;
   logic [31:0] model [15];
   int          n_cmp = 0;
   int          n_bad = 0;

   register_file dut (
      .clk(clk), .rst(rst), .A1(A1), .A2(A2), .A3(A3),
      .WD3(WD3), .WE3(WE3), .R15(R15), .RD1(RD1), .RD2(RD2)
   );

   always #5 clk = ~clk;

   task automatic do_write(input logic [8:0] addr, input logic [31:0] data);
      @(negedge clk);
      WE3 = 1'b1; A3 = addr; WD3 = data;
      @(posedge clk); #1;
      WE3 = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b0; WE3 = 1'b1; A3 = 9'd5; WD3 = 32'hFFFF_FFFF;
      A1 = 9'd5; A2 = 9'd15; R15 = 32'h0000_0100;
      exp_q.push_back(32'h0); exp_q.push_back(32'h0000_0100);
      @(posedge clk); #1;
      exp1 = exp_q.pop_front(); exp2 = exp_q.pop_front(); n_cmp += 2;
      if (RD1 !== exp1) begin n_bad++; $display("FAIL reset_rd1: got %h want %h", RD1, exp1); end
      if (RD2 !== exp2) begin n_bad++; $display("FAIL reset_rd2_pc: got %h want %h", RD2, exp2); end
      WE3 = 1'b0;
   endtask

   task automatic test_write_disabled;
      @(negedge clk);
      rst = 1'b1; WE3 = 1'b0; A3 = 9'd1; WD3 = 32'h00BC_614E; A1 = 9'd1;
      exp_q.push_back(32'h0);
      @(posedge clk); #1;
      exp1 = exp_q.pop_front(); n_cmp++;
      if (RD1 !== exp1) begin n_bad++; $display("FAIL we_off: got %h want %h", RD1, exp1); end
   endtask

   task automatic test_write_read;
      do_write(9'd2, 32'h0539_7FB1);
      model[2] = 32'h0539_7FB1;
      A1 = 9'd2; A2 = 9'd2;
      exp_q.push_back(model[2]); exp_q.push_back(model[2]);
      #1;
      exp1 = exp_q.pop_front(); exp2 = exp_q.pop_front(); n_cmp += 2;
      if (RD1 !== exp1) begin n_bad++; $display("FAIL wr_rd1: got %h want %h", RD1, exp1); end
      if (RD2 !== exp2) begin n_bad++; $display("FAIL wr_rd2: got %h want %h", RD2, exp2); end
   endtask

   task automatic test_pc_redirect;
      @(negedge clk); #2;
      R15 = 32'h10; A1 = 9'd15;
      exp_q.push_back(32'h10);
      #1;
      exp1 = exp_q.pop_front(); n_cmp++;
      if (RD1 !== exp1) begin n_bad++; $display("FAIL pc_read: got %h want %h", RD1, exp1); end
      do_write(9'd15, 32'hDEAD_BEEF);
      exp_q.push_back(32'h10);
      #1;
      exp1 = exp_q.pop_front(); n_cmp++;
      if (RD1 !== exp1) begin n_bad++; $display("FAIL pc_write_dropped: got %h want %h", RD1, exp1); end
      R15 = 32'h14;
      exp_q.push_back(32'h14);
      #1;
      exp1 = exp_q.pop_front(); n_cmp++;
      if (RD1 !== exp1) begin n_bad++; $display("FAIL pc_track: got %h want %h", RD1, exp1); end
   endtask

   task automatic test_invalid_addr;
      do_write(9'h012, 32'hAAAA_5555);
      A1 = 9'h012; A2 = 9'd2;
      exp_q.push_back(32'h0); exp_q.push_back(model[2]);
      #1;
      exp1 = exp_q.pop_front(); exp2 = exp_q.pop_front(); n_cmp += 2;
      if (RD1 !== exp1) begin n_bad++; $display("FAIL invalid_rd: got %h want %h", RD1, exp1); end
      if (RD2 !== exp2) begin n_bad++; $display("FAIL invalid_alias_r2: got %h want %h", RD2, exp2); end
      A1 = 9'h1F0;
      exp_q.push_back(32'h0);
      #1;
      exp1 = exp_q.pop_front(); n_cmp++;
      if (RD1 !== exp1) begin n_bad++; $display("FAIL invalid_hi: got %h want %h", RD1, exp1); end
   endtask

   task automatic test_same_edge_hazard;
      @(negedge clk);
      A1 = 9'd3; WE3 = 1'b1; A3 = 9'd3; WD3 = 32'h77;
      exp_q.push_back(32'h0);
      #1;
      exp1 = exp_q.pop_front(); n_cmp++;
      if (RD1 !== exp1) begin n_bad++; $display("FAIL hazard_before: got %h want %h", RD1, exp1); end
      model[3] = 32'h77;
      exp_q.push_back(model[3]);
      @(posedge clk); #1;
      WE3 = 1'b0;
      exp1 = exp_q.pop_front(); n_cmp++;
      if (RD1 !== exp1) begin n_bad++; $display("FAIL hazard_after: got %h want %h", RD1, exp1); end
   endtask

   task automatic test_back_to_back;
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         WE3 = 1'b1; A3 = 9'(i); WD3 = (32'(i) * 32'h0101_0101) ^ 32'hA500_0000;
         model[i] = WD3;
      end
      @(negedge clk);
      WE3 = 1'b0;
      for (int i = 0; i < 15; i++) begin
         A1 = 9'(i); A2 = 9'(14 - i);
         exp_q.push_back(model[i]); exp_q.push_back(model[14 - i]);
         #1;
         exp1 = exp_q.pop_front(); exp2 = exp_q.pop_front(); n_cmp += 2;
         if (RD1 !== exp1) begin n_bad++; $display("FAIL b2b_rd1[%0d]: got %h want %h", i, RD1, exp1); end
         if (RD2 !== exp2) begin n_bad++; $display("FAIL b2b_rd2[%0d]: got %h want %h", 14 - i, RD2, exp2); end
      end
   endtask

   task automatic test_async_reset;
      do_write(9'd2, 32'h0539_7FB1);
      do_write(9'd14, 32'h0000_1234);
      A1 = 9'd2; A2 = 9'd14;
      exp_q.push_back(32'h0539_7FB1); exp_q.push_back(32'h0000_1234);
      @(negedge clk); #2;
      exp1 = exp_q.pop_front(); exp2 = exp_q.pop_front(); n_cmp += 2;
      if (RD1 !== exp1) begin n_bad++; $display("FAIL preload_r2: got %h want %h", RD1, exp1); end
      if (RD2 !== exp2) begin n_bad++; $display("FAIL preload_r14: got %h want %h", RD2, exp2); end
      rst = 1'b0;
      exp_q.push_back(32'h0); exp_q.push_back(32'h0);
      #1;
      exp1 = exp_q.pop_front(); exp2 = exp_q.pop_front(); n_cmp += 2;
      if (RD1 !== exp1) begin n_bad++; $display("FAIL arst_r2: got %h want %h", RD1, exp1); end
      if (RD2 !== exp2) begin n_bad++; $display("FAIL arst_r14: got %h want %h", RD2, exp2); end
      A1 = 9'd15; R15 = 32'h0000_0055;
      exp_q.push_back(32'h0000_0055);
      #1;
      exp1 = exp_q.pop_front(); n_cmp++;
      if (RD1 !== exp1) begin n_bad++; $display("FAIL arst_pc: got %h want %h", RD1, exp1); end
      WE3 = 1'b1; A3 = 9'd4; WD3 = 32'h99; A1 = 9'd4;
      exp_q.push_back(32'h0);
      @(posedge clk); #1;
      exp1 = exp_q.pop_front(); n_cmp++;
      if (RD1 !== exp1) begin n_bad++; $display("FAIL arst_write_blocked: got %h want %h", RD1, exp1); end
      @(negedge clk);
      rst = 1'b1;
      exp_q.push_back(32'h99);
      @(posedge clk); #1;
      WE3 = 1'b0;
      exp1 = exp_q.pop_front(); n_cmp++;
      if (RD1 !== exp1) begin n_bad++; $display("FAIL first_write_after_rst: got %h want %h", RD1, exp1); end
   endtask

   initial begin
      rst = 1'b0; WE3 = 1'b0; A1 = '0; A2 = '0; A3 = '0; WD3 = '0; R15 = '0;
      for (int i = 0; i < 15; i++) model[i] = 32'h0;
      test_reset;
      test_write_disabled;
      test_write_read;
      test_pc_redirect;
      test_invalid_addr;
      test_same_edge_hazard;
      test_back_to_back;
      test_async_reset;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
